xor_cipher_stage: RTL and testbench

- Sits directly downstream of the 32-bit key register. While kset=1 it captures the four key bytes the key register emits on its dout.
- It then encrypts or decrypts a byte stream by XORing each data byte with a rotating key byte.
- Valid/ready handshake on both sides, 1-cycle registered latency, frame delimiting via last.
- Feeds the output byte sink (UART TX / result buffer).

---
 rtl/cipher_pkg.sv | 22 ++
 rtl/key_capture.sv | 56 +++++
 rtl/xor_cipher_stage.sv | 153 +++++++++++++++
 tb/tb_xor_cipher_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cipher_pkg.sv
// Shared types and defaults for the XOR cipher stage and its key capture block.
package cipher_pkg;

   localparam int unsigned KEY_BYTES = 4;
   localparam int unsigned DATA_W    = 8;

   typedef enum logic [1:0] {
      KEYLOAD,
      READY,
      STREAM
   } state_e;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/key_capture.sv
// Captures key bytes from the key register, pairing each byte with the slot index
// that addressed it one cycle earlier, and tracks which slots have been filled.
module key_capture #(
   parameter  int unsigned KEY_BYTES = cipher_pkg::KEY_BYTES,
   parameter  int unsigned DATA_W    = cipher_pkg::DATA_W,
   localparam int unsigned SL_W      = cipher_pkg::clog2(KEY_BYTES)
) (
   input  logic              dclk,
   input  logic              reset,
   input  logic              kset,
   input  logic [DATA_W-1:0] key_in,
   input  logic [SL_W-1:0]   key_sl,
   input  logic              cap_en,
   input  logic              clear,
   output logic [DATA_W-1:0] key [KEY_BYTES],
   output logic              all_set
);
   import cipher_pkg::*;

   logic [DATA_W-1:0]    key_q [KEY_BYTES];
   logic [DATA_W-1:0]    key_d [KEY_BYTES];
   logic [KEY_BYTES-1:0] mask_q, mask_d;
   logic [SL_W-1:0]      sl_dly_q;
   logic                 kset_dly_q;

   // key_in lags key_sl by one cycle, so capture uses the delayed slot index and
   // only trusts key_in once kset has been high for two consecutive cycles.
   always_comb begin
      key_d  = key_q;
      mask_d = mask_q;
      if (clear) begin
         mask_d = '0;
      end else if (cap_en && kset && kset_dly_q) begin
         key_d[sl_dly_q]  = key_in;
         mask_d[sl_dly_q] = 1'b1;
      end
   end

   always_ff @(posedge dclk) begin
      if (reset) begin
         for (int i = 0; i < int'(KEY_BYTES); i++) key_q[i] <= '0;
         mask_q     <= '0;
         sl_dly_q   <= '0;
         kset_dly_q <= 1'b0;
      end else begin
         key_q      <= key_d;
         mask_q     <= mask_d;
         sl_dly_q   <= key_sl;
         kset_dly_q <= kset;
      end
   end

   assign key     = key_q;
   assign all_set = &mask_q;

endmodule

// File: rtl/xor_cipher_stage.sv
// Byte-stream XOR cipher: each byte is XORed with a rotating key byte, restarting at
// key[0] every frame, behind a one-deep registered valid/ready output stage.
module xor_cipher_stage #(
   parameter  int unsigned KEY_BYTES = cipher_pkg::KEY_BYTES,
   parameter  int unsigned DATA_W    = cipher_pkg::DATA_W,
   parameter  int unsigned FCNT_W    = 16,
   localparam int unsigned SL_W      = cipher_pkg::clog2(KEY_BYTES)
) (
   input  logic              dclk,
   input  logic              reset,
   input  logic              kset,
   input  logic [DATA_W-1:0] key_in,
   input  logic [SL_W-1:0]   key_sl,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   input  logic              in_last,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              out_last,
   input  logic              out_ready,
   output logic              key_loaded,
   output logic [FCNT_W-1:0] frame_cnt
);
   import cipher_pkg::*;

   state_e            state_q, state_d;
   logic              pend_q, pend_d;
   logic              key_loaded_q, key_loaded_d;
   logic [SL_W-1:0]   idx_q, idx_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic              out_last_q, out_last_d;
   logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

   logic [DATA_W-1:0] key [KEY_BYTES];
   logic              all_set, mask_clr, cap_en, accept;

   key_capture #(
      .KEY_BYTES (KEY_BYTES),
      .DATA_W    (DATA_W)
   ) u_key_capture (
      .dclk    (dclk),
      .reset   (reset),
      .kset    (kset),
      .key_in  (key_in),
      .key_sl  (key_sl),
      .cap_en  (cap_en),
      .clear   (mask_clr),
      .key     (key),
      .all_set (all_set)
   );

   always_ff @(posedge dclk) begin
      if (reset) begin
         state_q      <= KEYLOAD;
         pend_q       <= 1'b0;
         key_loaded_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pend_q       <= pend_d;
         key_loaded_q <= key_loaded_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pend_d       = pend_q;
      key_loaded_d = key_loaded_q;
      mask_clr     = 1'b0;
      unique case (state_q)
         KEYLOAD: begin
            if (!kset) begin
               mask_clr = 1'b1;
            end else if (all_set) begin
               state_d      = READY;
               key_loaded_d = 1'b1;
            end
         end
         READY: begin
            if (accept) begin
               if (!in_last) state_d = STREAM;
            end else if (!kset) begin
               state_d      = KEYLOAD;
               mask_clr     = 1'b1;
               key_loaded_d = 1'b0;
            end
         end
         STREAM: begin
            // A key change mid-frame is deferred; the held key finishes the frame.
            if (!kset) pend_d = 1'b1;
            if (accept && in_last) begin
               if (pend_q || !kset) begin
                  state_d      = KEYLOAD;
                  mask_clr     = 1'b1;
                  key_loaded_d = 1'b0;
                  pend_d       = 1'b0;
               end else begin
                  state_d = READY;
               end
            end
         end
         default: state_d = KEYLOAD;
      endcase
   end

   always_comb begin
      in_ready = (state_q != KEYLOAD) && (!out_valid_q || out_ready);
      cap_en   = (state_q == KEYLOAD);
   end

   assign accept = in_valid && in_ready;

   always_comb begin
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_valid_d = out_valid_q;
      idx_d       = idx_q;
      frame_cnt_d = frame_cnt_q;
      if (accept) begin
         out_data_d  = in_data ^ key[idx_q];
         out_last_d  = in_last;
         out_valid_d = 1'b1;
         idx_d       = in_last ? '0 : idx_q + SL_W'(1);
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
      if (out_valid_q && out_ready && out_last_q) frame_cnt_d = frame_cnt_q + FCNT_W'(1);
   end

   always_ff @(posedge dclk) begin
      if (reset) begin
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         idx_q       <= '0;
         frame_cnt_q <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         idx_q       <= idx_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign out_last   = out_last_q;
   assign key_loaded = key_loaded_q;
   assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_xor_cipher_stage.sv
// Directed bench for xor_cipher_stage with a small registered key-register model.
module tb_xor_cipher_stage;

   logic        dclk;
   logic        reset;
   logic        kset;
   logic [7:0]  key_in;
   logic [1:0]  key_sl;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_last;
   logic        in_ready;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_last;
   logic        out_ready;
   logic        key_loaded;
   logic [15:0] frame_cnt;

   logic [31:0] keyreg;
   int          total;
   int          bad;

   typedef struct {
      logic [7:0] din;
      logic       last;
      logic [7:0] dout;
      logic       olast;
   } vec_t;

   vec_t vt [8];
   vec_t vb [4];
   vec_t vk [4];

   xor_cipher_stage #(
      .KEY_BYTES (4),
      .DATA_W    (8),
      .FCNT_W    (16)
   ) dut (
      .dclk       (dclk),
      .reset      (reset),
      .kset       (kset),
      .key_in     (key_in),
      .key_sl     (key_sl),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_last   (out_last),
      .out_ready  (out_ready),
      .key_loaded (key_loaded),
      .frame_cnt  (frame_cnt)
   );

   initial dclk = 1'b0;
   always #5 dclk = ~dclk;

   // Key register: dout is a registered function of the slot index.
   always @(posedge dclk) key_in <= keyreg[8*key_sl +: 8];

   task automatic step();
      @(posedge dclk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   initial begin
      int n;
      total = 0;
      bad   = 0;

      vt[0] = '{8'hAA, 1'b0, 8'hBB, 1'b0};
      vt[1] = '{8'hBB, 1'b0, 8'h99, 1'b0};
      vt[2] = '{8'hCC, 1'b0, 8'hFF, 1'b0};
      vt[3] = '{8'hDD, 1'b0, 8'h99, 1'b0};
      vt[4] = '{8'hEE, 1'b1, 8'hFF, 1'b1};
      vt[5] = '{8'h01, 1'b0, 8'h10, 1'b0};
      vt[6] = '{8'h02, 1'b1, 8'h20, 1'b1};
      vt[7] = '{8'h03, 1'b1, 8'h12, 1'b1};

      vb[0] = '{8'hBB, 1'b0, 8'h99, 1'b0};
      vb[1] = '{8'hCC, 1'b0, 8'hFF, 1'b0};
      vb[2] = '{8'hDD, 1'b0, 8'h99, 1'b0};
      vb[3] = '{8'hEE, 1'b1, 8'hFF, 1'b1};

      vk[0] = '{8'h01, 1'b0, 8'h10, 1'b0};
      vk[1] = '{8'h02, 1'b0, 8'h20, 1'b0};
      vk[2] = '{8'h03, 1'b0, 8'h30, 1'b0};
      vk[3] = '{8'h04, 1'b1, 8'h40, 1'b1};

      keyreg    = 32'h4433_2211;
      reset     = 1'b1;
      kset      = 1'b0;
      key_sl    = 2'd0;
      in_data   = 8'h00;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      step();
      step();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_key_loaded", 32'(key_loaded), 32'd0);
      check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      reset = 1'b0;

      // Key load: slot 3 byte lands at the fifth edge, key_loaded one edge later.
      kset   = 1'b1;
      key_sl = 2'd0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("key_loaded_early", 32'(key_loaded), 32'd0);
         check("in_ready_keyload", 32'(in_ready), 32'd0);
         key_sl = 2'(i + 1);
      end
      step();
      check("key_loaded_rise", 32'(key_loaded), 32'd1);
      check("in_ready_loaded", 32'(in_ready), 32'd1);

      // Full-throughput stream followed by two short frames.
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_data  = vt[i].din;
         in_last  = vt[i].last;
         #1;
         check("tbl_in_ready", 32'(in_ready), 32'd1);
         step();
         check("tbl_out_valid", 32'(out_valid), 32'd1);
         check("tbl_out_data", 32'(out_data), 32'(vt[i].dout));
         check("tbl_out_last", 32'(out_last), 32'(vt[i].olast));
         if (i == 5) check("tbl_frame_cnt_mid", 32'(frame_cnt), 32'd1);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      step();
      check("tbl_drain_valid", 32'(out_valid), 32'd0);
      check("tbl_frame_cnt", 32'(frame_cnt), 32'd3);

      // Backpressure: first output held for three cycles.
      in_valid = 1'b1;
      in_data  = 8'hAA;
      in_last  = 1'b0;
      step();
      out_ready = 1'b0;
      in_data   = 8'hBB;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_out_data", 32'(out_data), 32'hBB);
         check("bp_out_last", 32'(out_last), 32'd0);
         step();
      end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = vb[i].din;
         in_last = vb[i].last;
         #1;
         check("bp_rel_in_ready", 32'(in_ready), 32'd1);
         step();
         check("bp_rel_out_data", 32'(out_data), 32'(vb[i].dout));
         check("bp_rel_out_last", 32'(out_last), 32'(vb[i].olast));
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      step();
      check("bp_frame_cnt", 32'(frame_cnt), 32'd4);
      check("bp_drain_valid", 32'(out_valid), 32'd0);

      // kset drops after byte 2; bytes 3 and 4 still use the held key.
      for (int i = 0; i < 4; i++) begin
         if (i == 2) kset = 1'b0;
         in_valid = 1'b1;
         in_data  = vk[i].din;
         in_last  = vk[i].last;
         #1;
         check("kd_in_ready", 32'(in_ready), 32'd1);
         step();
         check("kd_out_data", 32'(out_data), 32'(vk[i].dout));
         check("kd_out_last", 32'(out_last), 32'(vk[i].olast));
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      #1;
      check("kd_key_loaded", 32'(key_loaded), 32'd0);
      check("kd_in_ready_off", 32'(in_ready), 32'd0);
      step();
      check("kd_frame_cnt", 32'(frame_cnt), 32'd5);
      check("kd_in_ready_held", 32'(in_ready), 32'd0);

      // Reload with a different key; bounded wait for key_loaded.
      keyreg = 32'h8877_6655;
      kset   = 1'b1;
      key_sl = 2'd0;
      n      = 0;
      while (!key_loaded && n < 20) begin
         step();
         key_sl = key_sl + 2'd1;
         n++;
      end
      check("reload_key_loaded", 32'(key_loaded), 32'd1);
      check("reload_cycles", 32'(n), 32'd6);

      // Reset with a pending output held under backpressure.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h00;
      in_last   = 1'b0;
      step();
      in_valid = 1'b0;
      check("pre_rst_out_valid", 32'(out_valid), 32'd1);
      check("pre_rst_out_data", 32'(out_data), 32'h55);
      reset = 1'b1;
      step();
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_key_loaded", 32'(key_loaded), 32'd0);
      check("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd0);
      reset = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running, want finished");
      $fatal(1);
   end

endmodule
